// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// memory_arbiter : single-port RAM arbiter, data requests win over ifetch.
// Optional feature: define MEMORY_ARBITER_COUNT_EN for icount/dcount counters.
// Revision: 1.0
// ============================================================================
module memory_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err,
  output logic [31:0] icount,
  output logic [31:0] dcount
);

  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_dAddr;
  logic [31:0] r_dStore;
  logic [31:0] r_iAddr;
  logic        r_dWrite;
  logic        w_done;
  logic        w_err;
  logic        w_dHitSet;
  logic        w_iHitSet;

  always_comb begin
    w_nextState = r_state;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    w_err       = (ramstate == c_ERROR);
    w_done      = (ramstate == c_ACCESS) || (ramstate == c_ERROR);
    w_dHitSet   = 1'b0;
    w_iHitSet   = 1'b0;
    case (r_state)
      IDLE: begin
        if (dREN || dWEN) begin
          w_nextState = DACC;
        end else if (iREN) begin
          w_nextState = IACC;
        end
      end
      DACC: begin
        ramaddr  = r_dAddr;
        ramstore = r_dStore;
        ramWEN   = r_dWrite;
        ramREN   = !r_dWrite;
        if (w_done) begin
          w_nextState = IDLE;
          // A hit is only reported if the requester is still waiting for it
          w_dHitSet   = r_dWrite ? dWEN : dREN;
        end
      end
      IACC: begin
        ramaddr = r_iAddr;
        ramREN  = 1'b1;
        if (w_done) begin
          w_nextState = IDLE;
          w_iHitSet   = iREN;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_dAddr  <= '0;
      r_dStore <= '0;
      r_iAddr  <= '0;
      r_dWrite <= 1'b0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      mem_err  <= 1'b0;
      iload    <= '0;
      dload    <= '0;
    end else begin
      r_state <= w_nextState;
      ihit    <= w_iHitSet;
      dhit    <= w_dHitSet;
      mem_err <= (w_iHitSet || w_dHitSet) && w_err;
      if (r_state == IDLE) begin
        if (dREN || dWEN) begin
          r_dAddr  <= daddr;
          r_dStore <= dstore;
          r_dWrite <= dWEN;
        end else if (iREN) begin
          r_iAddr <= iaddr;
        end
      end
      if (w_dHitSet) begin
        dload <= w_err ? '0 : ramload;
      end
      if (w_iHitSet) begin
        iload <= w_err ? '0 : ramload;
      end
    end
  end

`ifdef MEMORY_ARBITER_COUNT_EN
  logic [31:0] r_iCount;
  logic [31:0] r_dCount;

  // Counters advance on the same edge that raises the hit pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_iCount <= '0;
      r_dCount <= '0;
    end else begin
      if (w_iHitSet) begin
        r_iCount <= r_iCount + 32'd1;
      end
      if (w_dHitSet) begin
        r_dCount <= r_dCount + 32'd1;
      end
    end
  end

  assign icount = r_iCount;
  assign dcount = r_dCount;
`else
  assign icount = '0;
  assign dcount = '0;
`endif

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset.
REQ-002 SHALL expose these ports (name, direction, width, meaning):
- CLK  in  1  rising-edge clock
- RST  in  1  reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  write data
- ihit  out  1  instruction access done (one-cycle pulse)
- iload  out  32  instruction word, valid with ihit
- dhit  out  1  data access done (one-cycle pulse)
- dload  out  32  read data, valid with dhit
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- mem_err  out  1  one-cycle pulse on a RAM ERROR completion
- icount  out  32  completed instruction accesses (see Configuration)
- dcount  out  32  completed data accesses (see Configuration)

Function
REQ-003 SHALL implement FSM states IDLE, DACC and IACC.
REQ-004 In IDLE, when dREN or dWEN is high, SHALL latch daddr, dstore and the op (write if dWEN, else read) and go to DACC; data SHALL win when it is requested at the same time as iREN.
REQ-005 In IDLE with only iREN high, SHALL latch iaddr and go to IACC.
REQ-006 When dREN and dWEN are both high, SHALL treat the request as a write.
REQ-007 In DACC/IACC, SHALL drive ramaddr/ramstore from the latched registers and hold ramREN or ramWEN high until completion; all RAM strobes SHALL be low in IDLE.
REQ-008 Completion SHALL occur on the cycle ramstate==ACCESS or ERROR; on the next edge the FSM SHALL return to IDLE.
REQ-009 On completion, SHALL register ramload into dload/iload and pulse dhit/ihit for exactly one cycle (the cycle after completion), but only if the originating request is still asserted on the completion cycle; otherwise it SHALL complete silently.
REQ-010 BUSY and FREE during DACC/IACC SHALL keep the state and its strobes unchanged (unbounded wait).
REQ-011 ERROR SHALL complete the access like ACCESS, pulse mem_err with the hit, and force the returned load data to 0.
REQ-012 Minimum latency SHALL be 3 edges from request to hit pulse: latch, RAM ACCESS, hit register.
REQ-013 Back-to-back requests SHALL have one IDLE cycle between accesses.
REQ-014 iload and dload SHALL hold their last value between hits.
REQ-015 The latched address and data SHALL NOT change during an access, even if inputs change.

Reset
REQ-016 With RST high at a clock edge, SHALL enter IDLE; ihit, dhit, mem_err, ramREN and ramWEN SHALL be 0; iload, dload, ramaddr, ramstore and the latches SHALL be 0; the counters SHALL be 0.
REQ-017 Reset during DACC/IACC SHALL abort the access and drop the strobes on the next edge, with no hit pulse.

Configuration
REQ-018 With macro MEMORY_ARBITER_COUNT_EN defined, SHALL increment icount/dcount by 1 on each ihit/dhit pulse (ERROR completions included), wrapping from 0xFFFFFFFF to 0.
REQ-019 Without MEMORY_ARBITER_COUNT_EN, icount and dcount SHALL be constant 0 with no counter registers; the ports remain present.

Verification
REQ-020 iREN=1, iaddr=0x40, ramstate BUSY for 2 cycles then ACCESS with ramload=0x8C010004 -> ramREN high and ramaddr=0x40 throughout; ihit pulses once with iload=0x8C010004.
REQ-021 iREN=1 and dWEN=1 in the same cycle, daddr=0x100, dstore=0xDEADBEEF -> DACC first with ramWEN and ramstore=0xDEADBEEF; dhit pulses; after one IDLE cycle, IACC runs.
REQ-022 dREN=1, daddr=0x200, ramstate=ERROR -> dhit and mem_err pulse together; dload=0.
REQ-023 RST asserted during the second BUSY cycle of a data read -> next cycle IDLE, strobes 0, no dhit; the counters stay 0.
REQ-024 With MEMORY_ARBITER_COUNT_EN defined, preload the counter to 0xFFFFFFFF via force and complete one ifetch -> icount=0; without the macro, icount=0 after 5 fetches.
REQ-025 dREN dropped before ACCESS -> the RAM read completes, no dhit, and dcount is unchanged.
